// File: rtl/smachine_pkg.sv
// S-Machine sequencer shared constants, state encoding and decode helper.
package smachine_pkg;

  localparam int MEM_AW = 9;
  localparam int DW     = 16;
  localparam int LAT_W  = 3;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LD_PRE,
    ST_EXEC,
    ST_ST_WR,
    ST_HALT
  } seq_state_t;

  // Loads with bit 10 set carry an immediate and skip the pre-read.
  function automatic logic is_mem_load(input logic [DW-1:0] inst);
    return (inst[15:12] == OP_LD) && !inst[10];
  endfunction

endpackage

// File: rtl/smachine_lat_counter.sv
// Loadable down-counter that times the memory read latency.
module smachine_lat_counter
  import smachine_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_val,
  output logic             o_done
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/smachine_exec_sequencer.sv
// S-Machine sequencer: fetch, load pre-read, one-cycle execute strobe and
// store commit, all sharing a single memory port.
module smachine_exec_sequencer
  import smachine_pkg::*;
#(
  parameter logic [MEM_AW-1:0] PROG_BASE = 9'h000,
  parameter int                MEM_LAT   = 1,
  parameter logic [3:0]        HALT_OP   = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [7:0]        pc_in,
  output logic [DW-1:0]     inst_out,
  output logic              cpu_enable,
  input  logic              cpu_rw,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [DW-1:0]     r_inst;
  logic [DW-1:0]     r_rdata;
  logic [15:0]       r_retired;
  logic              w_done;
  logic              w_load;
  logic [LAT_W-1:0]  w_lval;
  logic              w_is_halt;
  logic              w_to_ld;
  logic [MEM_AW-1:0] w_fetch_addr;

  assign w_fetch_addr = PROG_BASE + {1'b0, pc_in};
  assign w_is_halt    = (mem_rdata[15:12] == HALT_OP);
  assign w_to_ld      = w_done && !w_is_halt
                        && is_mem_load(mem_rdata);

  smachine_lat_counter u_lat (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_load (w_load),
    .i_val  (w_lval),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_lval = LAT_W'(MEM_LAT);
    unique case (r_state)
      ST_IDLE: begin
        if (run || step) begin
          w_next = ST_FETCH;
          w_load = 1'b1;
        end
      end
      ST_FETCH: begin
        if (w_done) begin
          if (w_is_halt) begin
            w_next = ST_HALT;
          end else if (w_to_ld) begin
            // Operand address went out in the last fetch cycle.
            w_next = ST_LD_PRE;
            w_load = 1'b1;
            w_lval = LAT_W'(MEM_LAT - 1);
          end else begin
            w_next = ST_EXEC;
          end
        end
      end
      ST_LD_PRE: begin
        if (w_done) begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_inst[15:12] == OP_ST) begin
          w_next = ST_ST_WR;
        end else if (run) begin
          w_next = ST_FETCH;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ST_WR: begin
        if (run) begin
          w_next = ST_FETCH;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst    <= '0;
      r_rdata   <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == ST_FETCH && w_done) begin
        r_inst <= mem_rdata;
      end
      if (r_state == ST_LD_PRE && w_done) begin
        r_rdata <= mem_rdata;
      end
      if (r_state == ST_EXEC) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (r_state)
      ST_FETCH: begin
        mem_addr = w_to_ld ? mem_rdata[8:0] : w_fetch_addr;
      end
      ST_LD_PRE: mem_addr = r_inst[8:0];
      ST_ST_WR: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_rw;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  assign inst_out   = r_inst;
  assign cpu_rdata  = r_rdata;
  assign retired    = r_retired;
  assign cpu_enable = (r_state == ST_EXEC);
  assign halted     = (r_state == ST_HALT);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_HALT);

endmodule
